// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default payload width for pipeline-stage controllers
package pipe_pkg;
  localparam int NPC_PIPE_W = 62;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// pipe_stage_ctrl_if: valid/ready/data handshake bundle between pipeline stages
interface pipe_stage_ctrl_if import pipe_pkg::*; #(parameter int WIDTH = NPC_PIPE_W);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: payload register with load enable and synchronous clear
module pipe_slot import pipe_pkg::*; #(parameter int WIDTH = NPC_PIPE_W) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk)
    if (i_clr) r_q <= '0;
    else if (i_load) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: valid/ready stage with main+skid registers, registered in_ready and transfer counter
module pipe_stage_ctrl import pipe_pkg::*; #(
  parameter int WIDTH = NPC_PIPE_W,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_stage_ctrl_if.slave      s_in,
  pipe_stage_ctrl_if.master     m_out,
  output logic [CNT_W-1:0]      xfer_cnt
);
  state_t           r_state, w_next;
  logic             w_in_fire, w_out_fire, w_ld_main, w_ld_skid, w_sel_skid;
  logic [WIDTH-1:0] w_main_q, w_skid_q;
  logic [CNT_W-1:0] r_cnt;
  assign s_in.ready  = (r_state != FULL) & !rst;
  assign m_out.valid = (r_state != EMPTY) & !rst;
  assign m_out.data  = w_main_q;
  assign w_in_fire   = s_in.valid & s_in.ready;
  assign w_out_fire  = m_out.valid & m_out.ready;
  assign xfer_cnt    = r_cnt;
  always_comb begin
    w_next     = r_state;
    w_ld_main  = 1'b0;
    w_ld_skid  = 1'b0;
    w_sel_skid = 1'b0;
    case (r_state)
      EMPTY: if (w_in_fire) begin
        w_next    = BUSY;
        w_ld_main = 1'b1;
      end
      BUSY: begin
        w_next    = w_in_fire ? (w_out_fire ? BUSY : FULL) : (w_out_fire ? EMPTY : BUSY);
        w_ld_main = w_in_fire & w_out_fire;
        w_ld_skid = w_in_fire & !w_out_fire;
      end
      FULL: if (w_out_fire) begin
        w_next     = BUSY;
        w_ld_main  = 1'b1;
        w_sel_skid = 1'b1;
      end
      default: w_next = EMPTY;
    endcase
    if (flush) begin
      w_next    = EMPTY;
      w_ld_main = 1'b0;
      w_ld_skid = 1'b0;
    end
  end
  always_ff @(posedge clk)
    r_state <= rst ? EMPTY : w_next;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (w_out_fire) r_cnt <= r_cnt + CNT_W'(1);
  pipe_slot #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .i_clr  (rst),
    .i_load (w_ld_main),
    .i_d    (w_sel_skid ? w_skid_q : s_in.data),
    .o_q    (w_main_q)
  );
  pipe_slot #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .i_clr  (rst),
    .i_load (w_ld_skid),
    .i_d    (s_in.data),
    .o_q    (w_skid_q)
  );
endmodule
